cpu_racket_ctrl: RTL and testbench

Computer opponent for the right-hand racket. Drives the same `up`/`down` level commands a player's buttons would, so it plugs straight into a `racket` instance in place of the button inputs. It reads ball and racket positions, applies a reaction delay and a dead zone, and updates its commands once per video frame.

---
 rtl/pong_pkg.sv | 29 ++
 rtl/cpu_racket_ctrl_dead_zone_cmp.sv | 37 +++
 rtl/cpu_racket_ctrl.sv | 158 +++++++++++++++
 tb/tb_cpu_racket_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the pong blocks (ball, racket, cpu_racket_ctrl).
//   SCREEN_H          visible screen height in pixels
//   DEFAULT_CENTER_Y  rest position the computer racket returns to
//   POS_W             width of every on-screen y coordinate
//   cpu_state_t       computer-opponent FSM encoding (also the debug value)
//   is_moving_state   true for the states that may command the racket
// -----------------------------------------------------------------------------
package pong_pkg;

    localparam int SCREEN_H         = 480;
    localparam int DEFAULT_CENTER_Y = 240;
    localparam int POS_W            = 10;

    // Encoding is visible on the debug port, so the values are fixed.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        TRACK  = 2'd2,
        RETURN = 2'd3
    } cpu_state_t;

    // Only TRACK and RETURN have a target; IDLE and WAIT keep the racket still.
    function automatic logic is_moving_state(input logic [1:0] st);
        return (st == TRACK) || (st == RETURN);
    endfunction

endpackage

// File: rtl/cpu_racket_ctrl_dead_zone_cmp.sv
// -----------------------------------------------------------------------------
// dead_zone_cmp
// Combinational comparator: decides whether the racket should move toward a
// target, ignoring errors inside a symmetric dead band.
//   target  in  POS_W  desired racket centre y
//   pos     in  POS_W  current racket centre y
//   up      out 1      target is more than DEAD_ZONE above (smaller y)
//   down    out 1      target is more than DEAD_ZONE below (larger y)
// up and down are mutually exclusive by construction.
// -----------------------------------------------------------------------------
module dead_zone_cmp
    import pong_pkg::*;
#(
    parameter int DEAD_ZONE = 8
) (
    input  logic [POS_W-1:0] target,
    input  logic [POS_W-1:0] pos,
    output logic             up,
    output logic             down
);

    localparam int DIFF_W = POS_W + 1;

    localparam logic signed [DIFF_W-1:0] DZ_POS = DIFF_W'(DEAD_ZONE);
    localparam logic signed [DIFF_W-1:0] DZ_NEG = -DZ_POS;

    // Both operands are unsigned pixel positions; one extra bit of headroom
    // makes the difference exact over the full coordinate range.
    logic signed [DIFF_W-1:0] diff;

    assign diff = $signed({1'b0, target}) - $signed({1'b0, pos});

    // Strict comparisons: an error of exactly DEAD_ZONE leaves the racket still.
    assign down = (diff > DZ_POS);
    assign up   = (diff < DZ_NEG);

endmodule

// File: rtl/cpu_racket_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_racket_ctrl
// Computer opponent for the right-hand racket. Produces the same up/down level
// commands as the player buttons so it can drive a racket instance directly.
//   clk         in  1      system clock
//   reset       in  1      synchronous, active-high
//   enable      in  1      opponent active; low forces IDLE with outputs 0
//   frame_tick  in  1      one-cycle pulse per video frame
//   ball_y      in  POS_W  ball centre y (0 = top)
//   ball_dir_x  in  1      1 = ball travelling toward this racket
//   racket_y    in  POS_W  racket centre y, fed back from the racket
//   up          out 1      move toward smaller y
//   down        out 1      move toward larger y
//   state       out 2      current FSM state (cpu_state_t encoding), debug
//
// Timing: frame_tick is a strobe with no handshake. On a cycle where it is
// high (and enable is high) the FSM advances once and new up/down/state appear
// on the following cycle. All other cycles hold every register, so input
// changes between ticks are ignored. enable low clears everything on the next
// edge with or without a tick; reset has priority over everything.
// -----------------------------------------------------------------------------
module cpu_racket_ctrl
    import pong_pkg::*;
#(
    parameter int DEAD_ZONE    = 8,
    parameter int REACT_FRAMES = 4,
    parameter int CENTER_Y     = DEFAULT_CENTER_Y
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             frame_tick,
    input  logic [POS_W-1:0] ball_y,
    input  logic             ball_dir_x,
    input  logic [POS_W-1:0] racket_y,
    output logic             up,
    output logic             down,
    output logic [1:0]       state
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_WAIT   = WAIT;
    localparam logic [1:0] ST_TRACK  = TRACK;
    localparam logic [1:0] ST_RETURN = RETURN;

    // Counter only needs to reach REACT_FRAMES-1.
    localparam int CNT_W = (REACT_FRAMES > 1) ? $clog2(REACT_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((REACT_FRAMES > 0) ? (REACT_FRAMES - 1) : 0);

    localparam logic [POS_W-1:0] CENTER_POS = POS_W'(CENTER_Y);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             up_q;
    logic             down_q;

    logic [POS_W-1:0] target;
    logic             cmp_up;
    logic             cmp_down;
    logic             move_en;

    // ------------------------------------------------------------------
    // Next-state logic; only consumed on an enabled tick.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (ball_dir_x) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_RETURN;
                end
            end
            ST_WAIT: begin
                // Ball turning away wins over finishing the reaction delay.
                if (!ball_dir_x) begin
                    state_d = ST_RETURN;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_TRACK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_TRACK: begin
                if (!ball_dir_x) begin
                    state_d = ST_RETURN;
                end
            end
            ST_RETURN: begin
                if (ball_dir_x) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // With no reaction delay WAIT is never occupied: go straight to TRACK.
        if ((REACT_FRAMES == 0) && (state_d == ST_WAIT)) begin
            state_d = ST_TRACK;
        end
    end

    // ------------------------------------------------------------------
    // Command computation uses the state being entered on this tick, so
    // the command and the state it belongs to update together.
    // ------------------------------------------------------------------
    always_comb begin
        target  = (state_d == ST_TRACK) ? ball_y : CENTER_POS;
        move_en = is_moving_state(state_d);
    end

    dead_zone_cmp #(
        .DEAD_ZONE (DEAD_ZONE)
    ) u_dead_zone_cmp (
        .target (target),
        .pos    (racket_y),
        .up     (cmp_up),
        .down   (cmp_down)
    );

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
        end else if (!enable) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
        end else if (frame_tick) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            up_q    <= move_en && cmp_up;
            down_q  <= move_en && cmp_down;
        end
    end

    assign up    = up_q;
    assign down  = down_q;
    assign state = state_q;

endmodule

// File: tb/tb_cpu_racket_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_racket_ctrl
// Directed scenarios followed by a randomised soak against a behavioural
// model. Expected {state, up, down} values are queued when a cycle is driven
// and popped when the DUT output for that cycle is sampled (1 time unit after
// the rising edge).
// -----------------------------------------------------------------------------
module tb_cpu_racket_ctrl;

    localparam int DEAD_ZONE    = 8;
    localparam int REACT_FRAMES = 4;
    localparam int CENTER_Y     = 240;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       frame_tick;
    logic [9:0] ball_y;
    logic       ball_dir_x;
    logic [9:0] racket_y;
    logic       up;
    logic       down;
    logic [1:0] state;

    always #5 clk = ~clk;

    cpu_racket_ctrl #(
        .DEAD_ZONE    (DEAD_ZONE),
        .REACT_FRAMES (REACT_FRAMES),
        .CENTER_Y     (CENTER_Y)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .frame_tick (frame_tick),
        .ball_y     (ball_y),
        .ball_dir_x (ball_dir_x),
        .racket_y   (racket_y),
        .up         (up),
        .down       (down),
        .state      (state)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [3:0] exp_q[$];   // {state, up, down}
    int         tests = 0;
    int         fails = 0;

    task automatic check(input string tag);
        logic [3:0] got;
        logic [3:0] e;
        got = {state, up, down};
        if (exp_q.size() == 0) begin
            e = 4'bxxxx;
        end else begin
            e = exp_q.pop_front();
        end
        tests++;
        assert (got === e) else begin
            fails++;
            $error("FAIL %s: got state=%0d up=%0b down=%0b, expected state=%0d up=%0b down=%0b",
                   tag, got[3:2], got[1], got[0], e[3:2], e[1], e[0]);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver: one clock cycle with or without a tick, then compare.
    // ------------------------------------------------------------------
    task automatic cyc(input logic tick, input logic [3:0] exp, input string tag);
        exp_q.push_back(exp);
        frame_tick = tick;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        check(tag);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model for the soak
    // ------------------------------------------------------------------
    int   m_state = 0;
    int   m_cnt   = 0;
    logic m_up    = 1'b0;
    logic m_dn    = 1'b0;

    task automatic model_step();
        int ns;
        int nc;
        int tgt;
        int diff;
        if (reset || !enable) begin
            m_state = 0;
            m_cnt   = 0;
            m_up    = 1'b0;
            m_dn    = 1'b0;
        end else if (frame_tick) begin
            ns = m_state;
            nc = m_cnt;
            if (m_state == 0) begin
                if (ball_dir_x) begin ns = 1; nc = 0; end
                else ns = 3;
            end else if (m_state == 1) begin
                if (!ball_dir_x) ns = 3;
                else if (m_cnt == REACT_FRAMES - 1) ns = 2;
                else nc = m_cnt + 1;
            end else if (m_state == 2) begin
                if (!ball_dir_x) ns = 3;
            end else begin
                if (ball_dir_x) begin ns = 1; nc = 0; end
            end
            tgt  = (ns == 2) ? int'(ball_y) : CENTER_Y;
            diff = tgt - int'(racket_y);
            m_up    = (ns >= 2) && (diff < -DEAD_ZONE);
            m_dn    = (ns >= 2) && (diff > DEAD_ZONE);
            m_state = ns;
            m_cnt   = nc;
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        reset      = 1'b1;
        enable     = 1'b1;
        frame_tick = 1'b0;
        ball_y     = 10'd0;
        ball_dir_x = 1'b1;
        racket_y   = 10'd0;

        // Reset, including reset coinciding with a tick.
        cyc(1'b0, 4'b0000, "reset_c1");
        cyc(1'b1, 4'b0000, "reset_with_tick");
        reset = 1'b0;
        cyc(1'b0, 4'b0000, "after_release");

        // Return to centre with dead-zone boundaries.
        ball_dir_x = 1'b0;
        racket_y   = 10'd100;
        cyc(1'b1, 4'b1101, "return_100");
        racket_y = 10'd232;
        cyc(1'b1, 4'b1100, "return_232_edge");
        racket_y = 10'd231;
        cyc(1'b1, 4'b1101, "return_231");
        racket_y = 10'd249;
        cyc(1'b1, 4'b1110, "return_249");
        racket_y = 10'd248;
        cyc(1'b1, 4'b1100, "return_248_edge");

        // Reaction delay from RETURN.
        ball_dir_x = 1'b1;
        ball_y     = 10'd400;
        racket_y   = 10'd240;
        cyc(1'b1, 4'b0100, "react_t1");
        cyc(1'b0, 4'b0100, "react_hold");
        cyc(1'b1, 4'b0100, "react_t2");
        cyc(1'b1, 4'b0100, "react_t3");
        cyc(1'b1, 4'b0100, "react_t4");
        cyc(1'b1, 4'b1001, "react_t5_track");

        // Hold between ticks, then reverse direction of command.
        ball_y = 10'd10;
        cyc(1'b0, 4'b1001, "hold_no_tick");
        cyc(1'b0, 4'b1001, "hold_no_tick2");
        cyc(1'b1, 4'b1010, "track_up");

        // Disable mid-track without a tick, then ticks while disabled.
        enable = 1'b0;
        cyc(1'b0, 4'b0000, "disable_no_tick");
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 4'b0000, "disabled_tick");
        end
        enable = 1'b1;
        cyc(1'b0, 4'b0000, "reenable_no_tick");

        // Abort during WAIT; counter must restart on re-entry.
        ball_dir_x = 1'b1;
        cyc(1'b1, 4'b0100, "abort_wait_t1");
        cyc(1'b1, 4'b0100, "abort_wait_t2");
        ball_dir_x = 1'b0;
        cyc(1'b1, 4'b1100, "abort_to_return");
        ball_dir_x = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 4'b0100, "rewait");
        end
        cyc(1'b1, 4'b1010, "rewait_track");

        // Ball turns away during TRACK.
        ball_dir_x = 1'b0;
        racket_y   = 10'd300;
        cyc(1'b1, 4'b1110, "track_to_return");

        // Randomised soak against the model.
        for (int i = 0; i < 10000; i++) begin
            reset      = (i == 0) || ($urandom_range(0, 499) == 0);
            enable     = ($urandom_range(0, 49) != 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 19) == 0) ball_dir_x = ~ball_dir_x;
            ball_y = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 0)
                racket_y = 10'($urandom_range(220, 260));
            else
                racket_y = 10'($urandom_range(0, 1023));
            model_step();
            exp_q.push_back({2'(m_state), m_up, m_dn});
            @(posedge clk);
            #1;
            check("soak");
            tests++;
            assert (!(up && down)) else begin
                fails++;
                $error("FAIL exclusion: got up=%0b down=%0b, expected not both 1", up, down);
            end
        end
        reset      = 1'b0;
        frame_tick = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
